// File: rtl/dmem_bus_ctrl_if.sv
// Core-side load/store handshake bundle for the data bus controller.
// The core drives the request fields and holds them until ready.
interface dmem_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        is_signed;
  logic [31:0] rdata;
  logic        ready;
  logic        fault;

  modport master (
    output req, we, addr, wdata, size, is_signed,
    input  rdata, ready, fault
  );

  modport slave (
    input  req, we, addr, wdata, size, is_signed,
    output rdata, ready, fault
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-side bus controller: decodes core loads/stores onto ROM, RAM, IO.
// Handles byte lanes, load extraction, IO wait states and timeout.
module dmem_bus_ctrl #(
  parameter int RAM_WORDS_LOG = 8,
  parameter int IO_ADDR_W     = 8,
  parameter int IO_TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     resetb,
  dmem_bus_ctrl_if.slave           bus,
  output logic [9:0]               rom_addr,
  input  logic [31:0]              rom_data,
  output logic                     ram_en,
  output logic [3:0]               ram_we,
  output logic [RAM_WORDS_LOG-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata,
  output logic                     io_req,
  output logic                     io_we,
  output logic [IO_ADDR_W-1:0]     io_addr,
  output logic [3:0]               io_be,
  output logic [31:0]              io_wdata,
  input  logic                     io_ack,
  input  logic [31:0]              io_rdata
);

  typedef enum logic [1:0] {
    S_IDLE, S_MEM, S_IO, S_FAULT
  } state_t;

  localparam logic [31:0] RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] IO_BASE  = 32'h8000_0000;
  localparam logic [7:0]  TO_LAST  = 8'(IO_TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic        lat_we, lat_rom, lat_sgn;
  logic [1:0]  lat_lo, lat_size;

  logic        in_rom, in_ram, in_io;
  logic        mis, bad, accept;
  logic [3:0]  be;
  logic [31:0] wrep, io_off;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  lo,
    input logic [1:0]  sz,
    input logic        sg
  );
    logic [31:0] s;
    s = w >> {lo, 3'b000};
    unique case (1'b1)
      sz == 2'b00: extract = {{24{sg & s[7]}}, s[7:0]};
      sz == 2'b01: extract = {{16{sg & s[15]}}, s[15:0]};
      default:     extract = s;
    endcase
  endfunction

  always_comb begin
    io_off = bus.addr - IO_BASE;
    in_rom = bus.addr[31:12] == 20'd0;
    in_ram = !bus.addr[31] && (bus.addr[30:28] != 3'd0);
    in_io  = bus.addr[31] && ((io_off >> IO_ADDR_W) == 32'd0);
    be     = 4'hF;
    wrep   = bus.wdata;
    mis    = 1'b0;
    unique case (1'b1)
      bus.size == 2'b00: begin
        be   = 4'b0001 << bus.addr[1:0];
        wrep = {4{bus.wdata[7:0]}};
      end
      bus.size == 2'b01: begin
        be   = 4'b0011 << bus.addr[1:0];
        wrep = {2{bus.wdata[15:0]}};
        mis  = bus.addr[0];
      end
      bus.size == 2'b10: mis = bus.addr[1:0] != 2'd0;
      default:           mis = 1'b1;
    endcase
    // store to ROM counts as a fault, not a silent drop
    bad    = mis || !(in_rom || in_ram || in_io)
          || (in_rom && bus.we);
    accept = (state == S_IDLE) && bus.req;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (bus.req) begin
        if (bad)        state_n = S_FAULT;
        else if (in_io) state_n = S_IO;
        else            state_n = S_MEM;
      end
      S_MEM:   state_n = S_IDLE;
      S_IO: begin
        if (io_ack)              state_n = S_IDLE;
        else if (cnt == TO_LAST) state_n = S_FAULT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= '0;
      io_be    <= 4'h0;
      io_wdata <= 32'd0;
      cnt      <= 8'd0;
      lat_we   <= 1'b0;
      lat_rom  <= 1'b0;
      lat_sgn  <= 1'b0;
      lat_lo   <= 2'd0;
      lat_size <= 2'd0;
    end else begin
      io_req <= state_n == S_IO;
      cnt    <= (state == S_IO) ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        lat_we   <= bus.we;
        lat_rom  <= in_rom;
        lat_sgn  <= bus.is_signed;
        lat_lo   <= bus.addr[1:0];
        lat_size <= bus.size;
      end
      if (accept && in_io && !bad) begin
        io_we    <= bus.we;
        io_addr  <= io_off[IO_ADDR_W-1:0];
        io_be    <= be;
        io_wdata <= wrep;
      end
    end
  end

  always_comb begin
    rom_addr  = bus.addr[11:2];
    ram_addr  = bus.addr[RAM_WORDS_LOG+1:2]
              - RAM_BASE[RAM_WORDS_LOG+1:2];
    ram_wdata = wrep;
    ram_en    = accept && !bad && in_ram;
    ram_we    = (ram_en && bus.we) ? be : 4'h0;
    bus.ready = 1'b0;
    bus.fault = 1'b0;
    bus.rdata = 32'd0;
    unique case (state)
      S_MEM: begin
        bus.ready = 1'b1;
        if (!lat_we)
          bus.rdata = extract(lat_rom ? rom_data : ram_rdata,
                              lat_lo, lat_size, lat_sgn);
      end
      S_IO: if (io_ack) begin
        bus.ready = 1'b1;
        if (!lat_we)
          bus.rdata = extract(io_rdata, lat_lo, lat_size, lat_sgn);
      end
      S_FAULT: begin
        bus.ready = 1'b1;
        bus.fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
